// File: rtl/dcache_ram_slave_if.sv
// Block-granular memory bus between the data cache (master) and main memory (slave).
// Read and write channels use a paired handshake: ready and valid return together.
interface dcache_ram_slave_if #(
  parameter int ADDR_W  = 12,
  parameter int BLOCK_W = 256
);
  logic [ADDR_W-1:0]  ram_axi_araddr;
  logic               ram_axi_arvalid;
  logic               ram_axi_arready;
  logic [BLOCK_W-1:0] ram_axi_rdata;
  logic               ram_axi_rvalid;
  logic               ram_axi_rready;
  logic [ADDR_W-1:0]  ram_axi_awaddr;
  logic               ram_axi_awvalid;
  logic               ram_axi_awready;
  logic [BLOCK_W-1:0] ram_axi_wdata;
  logic               ram_axi_wvalid;
  logic               ram_axi_wready;

  modport master (
    output ram_axi_araddr, ram_axi_arvalid, ram_axi_rready,
    output ram_axi_awaddr, ram_axi_awvalid, ram_axi_wdata, ram_axi_wvalid,
    input  ram_axi_arready, ram_axi_rdata, ram_axi_rvalid,
    input  ram_axi_awready, ram_axi_wready
  );

  modport slave (
    input  ram_axi_araddr, ram_axi_arvalid, ram_axi_rready,
    input  ram_axi_awaddr, ram_axi_awvalid, ram_axi_wdata, ram_axi_wvalid,
    output ram_axi_arready, ram_axi_rdata, ram_axi_rvalid,
    output ram_axi_awready, ram_axi_wready
  );
endinterface

// File: rtl/dcache_ram_slave.sv
// Main-memory slave for the data cache: serves block refills and dirty-victim
// writebacks after fixed programmable latencies; one transaction at a time.
module dcache_ram_slave #(
  parameter int ADDR_W    = 12,
  parameter int BLOCK_W   = 256,
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  dcache_ram_slave_if.slave   ram,
  output logic                busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [3:0] RD_LOAD = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [BLOCK_W-1:0] wdata_r, wdata_s;
  logic [BLOCK_W-1:0] rdata_r;
  logic               rd_fire_s;
  logic               arready_r, rvalid_r, awready_r, wready_r, busy_r;
  logic [BLOCK_W-1:0] mem_r [DEPTH];

  // The word offset selects nothing in a block-granular memory.
  logic unused_offset_s;
  assign unused_offset_s = ^{ram.ram_axi_araddr[1:0], ram.ram_axi_awaddr[1:0]};

  // Next-state, latency counter and request-latch logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    wdata_s   = wdata_r;
    rd_fire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Writeback wins: it always precedes the refill that caused it.
        if (ram.ram_axi_awvalid && ram.ram_axi_wvalid) begin
          state_s = ST_WR_WAIT;
          cnt_s   = WR_LOAD;
          idx_s   = ram.ram_axi_awaddr[ADDR_W-1:2];
          wdata_s = ram.ram_axi_wdata;
        end else if (ram.ram_axi_arvalid) begin
          state_s = ST_RD_WAIT;
          cnt_s   = RD_LOAD;
          idx_s   = ram.ram_axi_araddr[ADDR_W-1:2];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s   = ST_RD_RESP;
          rd_fire_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_RD_RESP: begin
        if (ram.ram_axi_rready) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RD_RESP;
        end
      end
      ST_WR_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_WR_RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_WR_RESP: state_s = ST_DONE;
      // DONE absorbs the cache's registered valid deassertion.
      ST_DONE:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // State, latched request and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      idx_r     <= {IDX_W{1'b0}};
      wdata_r   <= {BLOCK_W{1'b0}};
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      wdata_r   <= wdata_s;
      arready_r <= (state_s == ST_RD_RESP);
      rvalid_r  <= (state_s == ST_RD_RESP);
      awready_r <= (state_s == ST_WR_RESP);
      wready_r  <= (state_s == ST_WR_RESP);
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  // Read data is captured on the edge that raises rvalid and held until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= {BLOCK_W{1'b0}};
    end else if (rd_fire_s) begin
      rdata_r <= mem_r[idx_r];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Block storage; commits on the edge leaving WR_RESP, never while reset is held.
  always_ff @(posedge clk) begin
    if (rst && (state_r == ST_WR_RESP)) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  assign ram.ram_axi_arready = arready_r;
  assign ram.ram_axi_rvalid  = rvalid_r;
  assign ram.ram_axi_rdata   = rdata_r;
  assign ram.ram_axi_awready = awready_r;
  assign ram.ram_axi_wready  = wready_r;
  assign busy                = busy_r;

endmodule

// File: tb/tb_dcache_ram_slave.sv
// Bench for dcache_ram_slave: directed vector table, multi-cycle corner sequences
// and random traffic checked against a block-level memory model.
module tb_dcache_ram_slave;

  localparam int RL = 4;
  localparam int WL = 4;

  logic clk;
  logic rst;
  logic busy;

  int checks;
  int failures;

  logic [255:0] ref_mem [int];

  dcache_ram_slave_if #(.ADDR_W(12), .BLOCK_W(256)) bus ();

  dcache_ram_slave #(
    .ADDR_W(12), .BLOCK_W(256), .DEPTH(1024), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ram  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           is_wr;
    logic [11:0]  addr;
    logic [255:0] data;
    int           rdelay;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ram_axi_araddr  = 12'h000;
    bus.ram_axi_arvalid = 1'b0;
    bus.ram_axi_rready  = 1'b0;
    bus.ram_axi_awaddr  = 12'h000;
    bus.ram_axi_awvalid = 1'b0;
    bus.ram_axi_wdata   = 256'h0;
    bus.ram_axi_wvalid  = 1'b0;
  endtask

  function automatic logic [255:0] rand_block();
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic do_write(input logic [11:0] a, input logic [255:0] d, input string nm);
    int first;
    int pulses;
    int mis;
    bus.ram_axi_awaddr  = a;
    bus.ram_axi_wdata   = d;
    bus.ram_axi_awvalid = 1'b1;
    bus.ram_axi_wvalid  = 1'b1;
    step();
    first = 0; pulses = 0; mis = 0;
    for (int k = 1; k <= WL + 3; k++) begin
      step();
      if (bus.ram_axi_awready !== bus.ram_axi_wready) mis++;
      if (bus.ram_axi_wready === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
        bus.ram_axi_awvalid = 1'b0;
        bus.ram_axi_wvalid  = 1'b0;
      end
      if (k == WL + 1) chk({nm, " busy_hold"}, 256'(busy), 256'(1));
      if (k == WL + 2) chk({nm, " busy_fall"}, 256'(busy), 256'(0));
    end
    bus.ram_axi_awvalid = 1'b0;
    bus.ram_axi_wvalid  = 1'b0;
    chk({nm, " wr_latency"}, 256'(first), 256'(WL));
    chk({nm, " wr_pulses"}, 256'(pulses), 256'(1));
    chk({nm, " aw_w_pair"}, 256'(mis), 256'(0));
    ref_mem[int'(a[11:2])] = d;
  endtask

  task automatic do_read(input logic [11:0] a, input bit known, input logic [255:0] exp,
                         input int d, input string nm);
    int first;
    int rv;
    int unstable;
    int mis;
    logic [255:0] got;
    bus.ram_axi_araddr  = a;
    bus.ram_axi_arvalid = 1'b1;
    bus.ram_axi_rready  = (d == 0);
    step();
    first = 0; rv = 0; unstable = 0; mis = 0; got = 256'h0;
    for (int k = 1; k <= RL + d + 3; k++) begin
      step();
      if (bus.ram_axi_arready !== bus.ram_axi_rvalid) mis++;
      if (bus.ram_axi_rvalid === 1'b1) begin
        rv++;
        if (first == 0) begin
          first = k;
          got = bus.ram_axi_rdata;
        end else if (bus.ram_axi_rdata !== got) begin
          unstable++;
        end
        bus.ram_axi_rready = (rv > d);
      end else if (rv > 0) begin
        bus.ram_axi_arvalid = 1'b0;
      end
      if (k == RL + d + 1) chk({nm, " busy_hold"}, 256'(busy), 256'(1));
      if (k == RL + d + 2) chk({nm, " busy_fall"}, 256'(busy), 256'(0));
    end
    bus.ram_axi_arvalid = 1'b0;
    bus.ram_axi_rready  = 1'b0;
    chk({nm, " rd_latency"}, 256'(first), 256'(RL));
    chk({nm, " rvalid_cycles"}, 256'(rv), 256'(d + 1));
    chk({nm, " rdata_stable"}, 256'(unstable), 256'(0));
    chk({nm, " ar_r_pair"}, 256'(mis), 256'(0));
    if (known) chk({nm, " rdata"}, got, exp);
  endtask

  // Write and read raised together; arvalid stays high through the write's DONE.
  task automatic stale_test();
    logic [11:0]  a;
    logic [255:0] dv;
    logic [255:0] got;
    int wr_first, wr_cnt, rv_first, rv_rise;
    logic prev_rv;
    a  = 12'h140;
    dv = {16{16'hC3C3}};
    bus.ram_axi_araddr  = a;
    bus.ram_axi_arvalid = 1'b1;
    bus.ram_axi_awaddr  = a;
    bus.ram_axi_awvalid = 1'b1;
    bus.ram_axi_wdata   = dv;
    bus.ram_axi_wvalid  = 1'b1;
    bus.ram_axi_rready  = 1'b1;
    step();
    wr_first = 0; wr_cnt = 0; rv_first = 0; rv_rise = 0; prev_rv = 1'b0; got = 256'h0;
    for (int k = 1; k <= WL + RL + 14; k++) begin
      step();
      if (bus.ram_axi_wready === 1'b1) begin
        wr_cnt++;
        if (wr_first == 0) wr_first = k;
        bus.ram_axi_awvalid = 1'b0;
        bus.ram_axi_wvalid  = 1'b0;
      end
      if (bus.ram_axi_rvalid === 1'b1 && !prev_rv) begin
        rv_rise++;
        if (rv_first == 0) begin
          rv_first = k;
          got = bus.ram_axi_rdata;
        end
      end
      if (rv_rise > 0 && busy === 1'b0) bus.ram_axi_arvalid = 1'b0;
      prev_rv = bus.ram_axi_rvalid;
    end
    clear_inputs();
    chk("prio wr_first", 256'(wr_first), 256'(WL));
    chk("prio wr_count", 256'(wr_cnt), 256'(1));
    chk("prio rd_first", 256'(rv_first), 256'(WL + 3 + RL));
    chk("prio rd_count", 256'(rv_rise), 256'(1));
    chk("prio raw_data", got, dv);
    ref_mem[int'(a[11:2])] = dv;
  endtask

  task automatic reset_mid_write();
    logic [255:0] old_d;
    int wr_seen;
    old_d = {4{64'h1111_2222_3333_4444}};
    do_write(12'h014, old_d, "rstw_pre");
    bus.ram_axi_awaddr  = 12'h014;
    bus.ram_axi_wdata   = {4{64'h9999_8888_7777_6666}};
    bus.ram_axi_awvalid = 1'b1;
    bus.ram_axi_wvalid  = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rstw async_busy", 256'(busy), 256'(0));
    clear_inputs();
    wr_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.ram_axi_wready !== 1'b0 || busy !== 1'b0) wr_seen++;
    end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.ram_axi_wready !== 1'b0 || busy !== 1'b0) wr_seen++;
    end
    chk("rstw no_wready", 256'(wr_seen), 256'(0));
    do_read(12'h015, 1'b1, old_d, 0, "rstw_read");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[11];
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    clear_inputs();

    vt[0]  = '{1'b1, 12'h0A8, {8{32'hDEADBEEF}}, 0};
    vt[1]  = '{1'b0, 12'h0A8, {8{32'hDEADBEEF}}, 0};
    vt[2]  = '{1'b1, 12'h3FC, {32{8'hA5}}, 0};
    vt[3]  = '{1'b0, 12'h3FF, {32{8'hA5}}, 0};
    vt[4]  = '{1'b0, 12'h0A9, {8{32'hDEADBEEF}}, 3};
    vt[5]  = '{1'b1, 12'h000, {4{64'h0123456789ABCDEF}}, 0};
    vt[6]  = '{1'b1, 12'hFFC, {4{64'hFEDCBA9876543210}}, 0};
    vt[7]  = '{1'b0, 12'h002, {4{64'h0123456789ABCDEF}}, 1};
    vt[8]  = '{1'b0, 12'hFFD, {4{64'hFEDCBA9876543210}}, 0};
    vt[9]  = '{1'b1, 12'h0A8, {32{8'h5A}}, 0};
    vt[10] = '{1'b0, 12'h0AB, {32{8'h5A}}, 2};

    // Reset held with random request noise.
    for (int c = 0; c < 5; c++) begin
      bus.ram_axi_araddr  = 12'($urandom);
      bus.ram_axi_arvalid = 1'($urandom);
      bus.ram_axi_rready  = 1'($urandom);
      bus.ram_axi_awaddr  = 12'($urandom);
      bus.ram_axi_awvalid = 1'($urandom);
      bus.ram_axi_wdata   = rand_block();
      bus.ram_axi_wvalid  = 1'($urandom);
      step();
      chk("reset outs", 256'({bus.ram_axi_arready, bus.ram_axi_rvalid,
                              bus.ram_axi_awready, bus.ram_axi_wready, busy}), 256'(0));
      chk("reset rdata", bus.ram_axi_rdata, 256'h0);
    end
    clear_inputs();
    rst = 1'b1;
    step();
    chk("idle after reset", 256'(busy), 256'(0));

    for (int i = 0; i < 11; i++) begin
      if (vt[i].is_wr) do_write(vt[i].addr, vt[i].data, $sformatf("vec%0d", i));
      else do_read(vt[i].addr, 1'b1, vt[i].data, vt[i].rdelay, $sformatf("vec%0d", i));
    end

    stale_test();
    reset_mid_write();

    for (int i = 0; i < 40; i++) begin
      logic [9:0]   blk;
      logic [11:0]  a;
      int           key;
      blk = 10'h100 + 10'($urandom_range(0, 7));
      a   = {blk, 2'($urandom)};
      key = int'(blk);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, rand_block(), $sformatf("rnd%0d", i));
      end else if (ref_mem.exists(key)) begin
        do_read(a, 1'b1, ref_mem[key], $urandom_range(0, 2), $sformatf("rnd%0d", i));
      end else begin
        do_read(a, 1'b0, 256'h0, $urandom_range(0, 2), $sformatf("rnd%0d", i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
